hazard_unit: RTL

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/hazard_pkg.sv | 42 ++++
 rtl/hazard_unit_if.sv | 33 +++
 rtl/hazard_perf_cnt.sv | 30 +++
 rtl/hazard_unit.sv | 134 +++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard unit.
// HAZARD_FORWARDING_EN (defined in the top) selects forwarding instead of RAW stalls.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_MEM_WAIT = 1'b1
    } hz_state_e;

    localparam logic [1:0]  RESULT_SRC_LOAD = 2'b01;
    localparam logic [7:0]  WAIT_LIMIT      = 8'd255;
    localparam logic [15:0] STALL_CNT_MAX   = 16'hFFFF;

    // x0 is hardwired to zero, so it never creates a dependency.
    function automatic logic raw_match(input logic [4:0] rs,
                                       input logic [4:0] rd,
                                       input logic       we);
        return we && (rd != 5'd0) && (rs == rd);
    endfunction

    function automatic fwd_sel_e fwd_select(input logic [4:0] rs,
                                            input logic [4:0] rd_m,
                                            input logic       we_m,
                                            input logic [4:0] rd_w,
                                            input logic       we_w);
        fwd_sel_e sel;
        sel = FWD_RF;
        if (raw_match(rs, rd_m, we_m)) begin
            sel = FWD_M;
        end else if (raw_match(rs, rd_w, we_w)) begin
            sel = FWD_W;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Pipeline-to-hazard-unit signal bundle. The pipeline (master) drives register
// indices and stage status; the hazard unit (slave) returns stall/flush/forward controls.
interface hazard_unit_if;

    logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E;
    logic [4:0]  RdE, RdM, RdW;
    logic        RegWriteE, RegWriteM, RegWriteW;
    logic [1:0]  ResultSrcE;
    logic        PCSrcE, MemReqM, MemReadyM;

    logic [1:0]  ForwardAE, ForwardBE;
    logic        StallF, StallD, StallE, StallM;
    logic        FlushD, FlushE, FlushW;
    logic        MemTimeout;
    logic [15:0] StallCount;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output RegWriteE, RegWriteM, RegWriteW, ResultSrcE,
        output PCSrcE, MemReqM, MemReadyM,
        input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
        input  FlushD, FlushE, FlushW, MemTimeout, StallCount
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  RegWriteE, RegWriteM, RegWriteW, ResultSrcE,
        input  PCSrcE, MemReqM, MemReadyM,
        output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
        output FlushD, FlushE, FlushW, MemTimeout, StallCount
    );

endinterface

// File: rtl/hazard_perf_cnt.sv
// Saturating 16-bit counter of stalled fetch cycles; holds at all-ones instead of wrapping.
module hazard_perf_cnt
    import hazard_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        inc,
    output logic [15:0] count
);

    logic [15:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != STALL_CNT_MAX)) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: data-memory wait FSM with watchdog, load-use/RAW stalls,
// branch flushes and operand forwarding (forwarding only with HAZARD_FORWARDING_EN).
//
// state       | meaning
// ST_IDLE     | no outstanding data-memory wait (a 0-wait access never leaves here)
// ST_MEM_WAIT | data memory busy; wait counter running toward WAIT_LIMIT
module hazard_unit
    import hazard_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    hazard_unit_if.slave hz
);

    hz_state_e   state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        timeout_q, timeout_d;

    logic        mem_stall;
    logic        hazard_stall;
    logic        hazard_eff;
    logic        branch_flush;
    logic        stall_f, stall_d, stall_e, stall_m;
    logic        flush_d, flush_e, flush_w;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_count;

    assign mem_stall = hz.MemReqM & ~hz.MemReadyM;

`ifdef HAZARD_FORWARDING_EN
    logic load_e;

    assign load_e       = (hz.ResultSrcE == RESULT_SRC_LOAD);
    assign hazard_stall = load_e & (raw_match(hz.Rs1D, hz.RdE, hz.RegWriteE) |
                                    raw_match(hz.Rs2D, hz.RdE, hz.RegWriteE));
    assign fwd_a = fwd_select(hz.Rs1E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW);
    assign fwd_b = fwd_select(hz.Rs2E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW);
`else
    logic unused_fwd_inputs;

    // Without forwarding, any pending write in E or M must land before Decode reads it.
    assign hazard_stall = raw_match(hz.Rs1D, hz.RdE, hz.RegWriteE) |
                          raw_match(hz.Rs2D, hz.RdE, hz.RegWriteE) |
                          raw_match(hz.Rs1D, hz.RdM, hz.RegWriteM) |
                          raw_match(hz.Rs2D, hz.RdM, hz.RegWriteM);
    assign fwd_a = FWD_RF;
    assign fwd_b = FWD_RF;
    assign unused_fwd_inputs = ^{hz.Rs1E, hz.Rs2E, hz.RdW, hz.RegWriteW,
                                 (hz.ResultSrcE == RESULT_SRC_LOAD)};
`endif

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        unique case (state_q)
            ST_IDLE: begin
                if (mem_stall) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = '0;
                end
            end
            ST_MEM_WAIT: begin
                if (hz.MemReadyM) begin
                    state_d = ST_IDLE;
                end else begin
                    if (wait_cnt_q != WAIT_LIMIT) begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
                    if (wait_cnt_d == WAIT_LIMIT) begin
                        timeout_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A memory stall freezes everything; branch and hazard resolve once it lifts.
    always_comb begin
        hazard_eff   = hazard_stall & ~mem_stall;
        branch_flush = hz.PCSrcE & ~mem_stall;

        flush_d = branch_flush;
        flush_e = branch_flush | hazard_eff;
        flush_w = mem_stall;
        stall_f = mem_stall | hazard_eff;
        stall_d = (mem_stall | hazard_eff) & ~flush_d;
        stall_e = mem_stall & ~flush_e;
        stall_m = mem_stall;

        if (reset) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
            flush_w = 1'b1;
            stall_f = 1'b0;
            stall_d = 1'b0;
            stall_e = 1'b0;
            stall_m = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    hazard_perf_cnt u_perf_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_f),
        .count (stall_count)
    );

    assign hz.ForwardAE  = reset ? 2'b00 : fwd_a;
    assign hz.ForwardBE  = reset ? 2'b00 : fwd_b;
    assign hz.StallF     = stall_f;
    assign hz.StallD     = stall_d;
    assign hz.StallE     = stall_e;
    assign hz.StallM     = stall_m;
    assign hz.FlushD     = flush_d;
    assign hz.FlushE     = flush_e;
    assign hz.FlushW     = flush_w;
    assign hz.MemTimeout = timeout_q;
    assign hz.StallCount = stall_count;

endmodule
